// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types and constants.
//   INST_W        instruction / address width
//   RESET_PC_DEF  default PC after reset
//   NOP           value held in the instruction register after reset
//   fetch_state_t fetch FSM states
package mips_pkg;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_t;
endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with redirect and advance.
//   clk, rst      clock, asynchronous active-low reset (loads RESET_PC)
//   enable        advance pc by 4
//   redirect      load target (word aligned); wins over enable
//   target        redirect address
//   pc, pc_plus4  current pc and pc+4 (wraps modulo 2^INST_W)
module pc_register import mips_pkg::*; #(
    parameter int W = mips_pkg::INST_W,
    parameter logic [W-1:0] RESET_PC = mips_pkg::RESET_PC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         redirect,
    input  logic [W-1:0] target,
    output logic [W-1:0] pc,
    output logic [W-1:0] pc_plus4
);
    assign pc_plus4 = pc + W'(4);

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            pc <= RESET_PC;
        else if (redirect)
            pc <= target & ~W'(3);
        else if (enable)
            pc <= pc_plus4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage feeding the IF/ID register over a req/gnt/rvalid memory port.
//   clk, rst                  clock, asynchronous active-low reset
//   pc_ld                     1 = advance, 0 = stall IF
//   branch_taken/target       redirect pulse and address
//   imem_req/addr/gnt         request side of instruction memory
//   imem_rvalid/rdata         response side of instruction memory
//   inst, adder1, if_valid    fetched instruction, its PC+4, and valid flag
//   ifid_ld, ifid_flush       IF/ID load enable and registered flush pulse
module fetch_unit import mips_pkg::*; #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC_DEF,
    parameter int INST_W = mips_pkg::INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_ld,
    input  logic              branch_taken,
    input  logic [INST_W-1:0] branch_target,
    output logic              imem_req,
    output logic [INST_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] adder1,
    output logic              if_valid,
    output logic              ifid_ld,
    output logic              ifid_flush
);
    fetch_state_t state;
    logic drop;
    logic [INST_W-1:0] pc, pc_plus4;
    // a redirect leaves one request in flight whose response must be discarded
    logic in_flight;

    assign imem_req  = state == S_REQ;
    assign imem_addr = pc;
    assign ifid_ld   = if_valid & pc_ld & ~branch_taken;
    assign in_flight = (state == S_WAIT && !imem_rvalid) || (state == S_REQ && imem_gnt);

    pc_register #(.W(INST_W), .RESET_PC(INST_W'(RESET_PC))) u_pc (
        .clk      (clk),
        .rst      (rst),
        .enable   (state == S_HOLD && pc_ld),
        .redirect (branch_taken),
        .target   (branch_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= S_REQ;
            drop       <= 1'b0;
            inst       <= NOP;
            adder1     <= '0;
            if_valid   <= 1'b0;
            ifid_flush <= 1'b0;
        end else if (branch_taken) begin
            if_valid   <= 1'b0;
            ifid_flush <= 1'b1;
            drop       <= in_flight;
            state      <= in_flight ? S_WAIT : S_REQ;
        end else begin
            ifid_flush <= 1'b0;
            case (state)
                S_REQ:  if (imem_gnt) state <= S_WAIT;
                S_WAIT: if (imem_rvalid) begin
                    drop <= 1'b0;
                    if (drop)
                        state <= S_REQ;
                    else begin
                        inst     <= imem_rdata;
                        adder1   <= pc_plus4;
                        if_valid <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: if (pc_ld) begin
                    if_valid <= 1'b0;
                    state    <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
endmodule
